// File: rtl/oflow_calc_min_ctrl_pkg.sv
// Shared oflow core definitions: score/id widths, the saturated score value and the
// min-calculator controller state encoding.
package oflow_calc_min_ctrl_pkg;

  localparam int unsigned SCORE_LEN = 16;
  localparam int unsigned ID_LEN    = 8;

  localparam logic [SCORE_LEN-1:0] MAX_SCORE = '1;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StIssue,
    StWait,
    StOut
  } state_e;

endpackage

// File: rtl/oflow_calc_min_ctrl.sv
// Per-object controller that walks previous-frame candidates two at a time through the
// min-calculator and hands the result to the score board. Optional abort: OFLOW_CALC_MIN_TIMEOUT_EN.
module oflow_calc_min_ctrl
  import oflow_calc_min_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CAND    = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          reset_N,
  input  logic                          start_obj,
  input  logic [$clog2(MAX_CAND+1)-1:0] num_cand,
  output logic                          busy,
  output logic                          start_score_calc,
  output logic                          start_calc_min,
  input  logic                          done_calc_min,
  output logic [ID_LEN-1:0]             cand_id_0,
  output logic [ID_LEN-1:0]             cand_id_1,
  output logic                          cand_valid_1,
  input  logic [SCORE_LEN-1:0]          min_score_0,
  input  logic [SCORE_LEN-1:0]          min_score_1,
  input  logic [ID_LEN-1:0]             min_id_0,
  input  logic [ID_LEN-1:0]             min_id_1,
  output logic [SCORE_LEN-1:0]          res_score_0,
  output logic [ID_LEN-1:0]             res_id_0,
  output logic [SCORE_LEN-1:0]          res_score_1,
  output logic [ID_LEN-1:0]             res_id_1,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          err_timeout
);

  localparam int unsigned NumW  = $clog2(MAX_CAND + 1);
  localparam int unsigned BaseW = $clog2(MAX_CAND) + 1;
  localparam int unsigned CmpW  = ((BaseW > NumW) ? BaseW : NumW) + 1;

  state_e               state_q, state_d;
  logic [NumW-1:0]      num_q, num_d, num_sat;
  logic [BaseW-1:0]     base_q, base_d;
  logic [SCORE_LEN-1:0] res_score_0_q, res_score_0_d, res_score_1_q, res_score_1_d;
  logic [ID_LEN-1:0]    res_id_0_q, res_id_0_d, res_id_1_q, res_id_1_d;
  logic [CmpW-1:0]      num_ext, base_p1, base_p2;
  logic                 lanes_active;

  assign num_sat = (num_cand > NumW'(MAX_CAND)) ? NumW'(MAX_CAND) : num_cand;
  assign num_ext = CmpW'(num_q);
  assign base_p1 = CmpW'(base_q) + CmpW'(1);
  assign base_p2 = CmpW'(base_q) + CmpW'(2);

`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state_q       <= StIdle;
      num_q         <= '0;
      base_q        <= '0;
      res_score_0_q <= '0;
      res_score_1_q <= '0;
      res_id_0_q    <= '0;
      res_id_1_q    <= '0;
`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      base_q        <= base_d;
      res_score_0_q <= res_score_0_d;
      res_score_1_q <= res_score_1_d;
      res_id_0_q    <= res_id_0_d;
      res_id_1_q    <= res_id_1_d;
`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    base_d        = base_q;
    res_score_0_d = res_score_0_q;
    res_score_1_d = res_score_1_q;
    res_id_0_d    = res_id_0_q;
    res_id_1_d    = res_id_1_q;
`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_obj) begin
          num_d   = num_sat;
          base_d  = '0;
`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StInit;
        end
      end
      StInit: begin
        if (num_q == '0) begin
          // No candidates: report the "no match" result directly.
          res_score_0_d = MAX_SCORE;
          res_score_1_d = MAX_SCORE;
          res_id_0_d    = '0;
          res_id_1_d    = '0;
          state_d       = StOut;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (done_calc_min) begin
          base_d = BaseW'(base_p2);
          if (base_p2 >= num_ext) begin
            res_score_0_d = min_score_0;
            res_score_1_d = min_score_1;
            res_id_0_d    = min_id_0;
            res_id_1_d    = min_id_1;
            state_d       = StOut;
          end else begin
            state_d = StIssue;
          end
        end
`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          err_d         = 1'b1;
          res_score_0_d = MAX_SCORE;
          res_score_1_d = MAX_SCORE;
          res_id_0_d    = '0;
          res_id_1_d    = '0;
          state_d       = StOut;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StOut: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ids only change when base advances on a done, so they are stable through WAIT.
  assign lanes_active     = (state_q == StIssue) || (state_q == StWait);
  assign cand_id_0        = lanes_active ? ID_LEN'(base_q) : '0;
  assign cand_id_1        = lanes_active ? ID_LEN'(base_p1) : '0;
  assign cand_valid_1     = lanes_active && (base_p1 < num_ext);

  assign busy             = (state_q != StIdle);
  assign start_score_calc = (state_q == StInit);
  assign start_calc_min   = (state_q == StIssue);
  assign res_valid        = (state_q == StOut);

  assign res_score_0      = res_score_0_q;
  assign res_score_1      = res_score_1_q;
  assign res_id_0         = res_id_0_q;
  assign res_id_1         = res_id_1_q;

endmodule

// File: tb/tb_oflow_calc_min_ctrl.sv
// Directed bench for oflow_calc_min_ctrl; the abort scenario runs only when
// OFLOW_CALC_MIN_TIMEOUT_EN is defined.
module tb_oflow_calc_min_ctrl;
  import oflow_calc_min_ctrl_pkg::*;

  localparam int unsigned MaxCand = 32;
  localparam int unsigned NumW    = $clog2(MaxCand + 1);

  logic                 clk = 1'b0;
  logic                 reset_N;
  logic                 start_obj;
  logic [NumW-1:0]      num_cand;
  logic                 busy, start_score_calc, start_calc_min;
  logic                 done_calc_min;
  logic [ID_LEN-1:0]    cand_id_0, cand_id_1;
  logic                 cand_valid_1;
  logic [SCORE_LEN-1:0] min_score_0, min_score_1;
  logic [ID_LEN-1:0]    min_id_0, min_id_1;
  logic [SCORE_LEN-1:0] res_score_0, res_score_1;
  logic [ID_LEN-1:0]    res_id_0, res_id_1;
  logic                 res_valid, res_ready, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oflow_calc_min_ctrl #(
    .MAX_CAND   (MaxCand),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk             (clk),
    .reset_N         (reset_N),
    .start_obj       (start_obj),
    .num_cand        (num_cand),
    .busy            (busy),
    .start_score_calc(start_score_calc),
    .start_calc_min  (start_calc_min),
    .done_calc_min   (done_calc_min),
    .cand_id_0       (cand_id_0),
    .cand_id_1       (cand_id_1),
    .cand_valid_1    (cand_valid_1),
    .min_score_0     (min_score_0),
    .min_score_1     (min_score_1),
    .min_id_0        (min_id_0),
    .min_id_1        (min_id_1),
    .res_score_0     (res_score_0),
    .res_id_0        (res_id_0),
    .res_score_1     (res_score_1),
    .res_id_1        (res_id_1),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .err_timeout     (err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] s0, input logic [7:0] i0,
                           input logic [15:0] s1, input logic [7:0] i1);
    check({tag, ".score0"}, 32'(res_score_0), 32'(s0));
    check({tag, ".id0"},    32'(res_id_0),    32'(i0));
    check({tag, ".score1"}, 32'(res_score_1), 32'(s1));
    check({tag, ".id1"},    32'(res_id_1),    32'(i1));
  endtask

  task automatic set_min(input logic [15:0] s0, input logic [7:0] i0,
                         input logic [15:0] s1, input logic [7:0] i1);
    min_score_0 = s0;
    min_id_0    = i0;
    min_score_1 = s1;
    min_id_1    = i1;
  endtask

  initial begin
    reset_N       = 1'b0;
    start_obj     = 1'b0;
    num_cand      = '0;
    done_calc_min = 1'b0;
    res_ready     = 1'b0;
    set_min(16'h0, 8'h0, 16'h0, 8'h0);
    tick();
    tick();
    check("rst.busy", 32'(busy), 0);
    check("rst.res_valid", 32'(res_valid), 0);
    check("rst.start_score", 32'(start_score_calc), 0);
    check("rst.start_min", 32'(start_calc_min), 0);
    check("rst.err", 32'(err_timeout), 0);
    check_res("rst", 16'h0, 8'h0, 16'h0, 8'h0);
    reset_N = 1'b1;
    tick();
    check("idle.busy", 32'(busy), 0);

    // Four candidates, done three cycles after each start_calc_min.
    start_obj = 1'b1;
    num_cand  = 6'd4;
    tick();
    start_obj = 1'b0;
    check("n4.init.start_score", 32'(start_score_calc), 1);
    check("n4.init.busy", 32'(busy), 1);
    check("n4.init.start_min", 32'(start_calc_min), 0);
    tick();
    check("n4.iss0.start_min", 32'(start_calc_min), 1);
    check("n4.iss0.start_score", 32'(start_score_calc), 0);
    check("n4.iss0.id0", 32'(cand_id_0), 0);
    check("n4.iss0.id1", 32'(cand_id_1), 1);
    check("n4.iss0.v1", 32'(cand_valid_1), 1);
    tick();
    check("n4.wait0.start_min", 32'(start_calc_min), 0);
    start_obj = 1'b1;  // ignored while busy
    num_cand  = 6'd0;
    tick();
    start_obj = 1'b0;
    tick();
    check("n4.wait0.id0", 32'(cand_id_0), 0);
    check("n4.wait0.id1", 32'(cand_id_1), 1);
    check("n4.wait0.v1", 32'(cand_valid_1), 1);
    done_calc_min = 1'b1;
    set_min(16'd7, 8'd1, 16'd12, 8'd0);
    tick();
    done_calc_min = 1'b0;
    check("n4.iss1.start_min", 32'(start_calc_min), 1);
    check("n4.iss1.id0", 32'(cand_id_0), 2);
    check("n4.iss1.id1", 32'(cand_id_1), 3);
    check("n4.iss1.v1", 32'(cand_valid_1), 1);
    check("n4.iss1.res_valid", 32'(res_valid), 0);
    tick();
    tick();
    tick();
    check("n4.wait1.id0", 32'(cand_id_0), 2);
    check("n4.wait1.res_valid", 32'(res_valid), 0);
    done_calc_min = 1'b1;
    set_min(16'd5, 8'd2, 16'd9, 8'd0);
    tick();
    done_calc_min = 1'b0;
    set_min(16'hAAAA, 8'h55, 16'hBBBB, 8'h66);
    check("n4.out.res_valid", 32'(res_valid), 1);
    check("n4.out.start_min", 32'(start_calc_min), 0);
    check_res("n4.out", 16'd5, 8'd2, 16'd9, 8'd0);
    start_obj = 1'b1;
    num_cand  = 6'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    start_obj = 1'b0;
    check("n4.hold.res_valid", 32'(res_valid), 1);
    check("n4.hold.start_score", 32'(start_score_calc), 0);
    check_res("n4.hold", 16'd5, 8'd2, 16'd9, 8'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("n4.done.res_valid", 32'(res_valid), 0);
    check("n4.done.busy", 32'(busy), 0);

    // Three candidates: second pair has lane 1 invalid.
    start_obj = 1'b1;
    num_cand  = 6'd3;
    tick();
    start_obj = 1'b0;
    tick();
    check("n3.iss0.v1", 32'(cand_valid_1), 1);
    tick();
    done_calc_min = 1'b1;
    tick();
    done_calc_min = 1'b0;
    check("n3.iss1.start_min", 32'(start_calc_min), 1);
    check("n3.iss1.id0", 32'(cand_id_0), 2);
    check("n3.iss1.id1", 32'(cand_id_1), 3);
    check("n3.iss1.v1", 32'(cand_valid_1), 0);
    tick();
    done_calc_min = 1'b1;
    set_min(16'd3, 8'd1, 16'hFFFF, 8'd0);
    tick();
    done_calc_min = 1'b0;
    check("n3.out.res_valid", 32'(res_valid), 1);
    check_res("n3.out", 16'd3, 8'd1, 16'hFFFF, 8'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // No candidates: straight from INIT to OUT with the "no match" result.
    set_min(16'h1234, 8'h12, 16'h5678, 8'h34);
    start_obj = 1'b1;
    num_cand  = 6'd0;
    tick();
    start_obj = 1'b0;
    check("n0.init.start_score", 32'(start_score_calc), 1);
    check("n0.init.start_min", 32'(start_calc_min), 0);
    tick();
    check("n0.out.res_valid", 32'(res_valid), 1);
    check("n0.out.start_min", 32'(start_calc_min), 0);
    check_res("n0.out", 16'hFFFF, 8'd0, 16'hFFFF, 8'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Over-range count saturates to MAX_CAND: exactly 16 pairs, last pair ids 30/31.
    start_obj = 1'b1;
    num_cand  = 6'd40;
    tick();
    start_obj = 1'b0;
    tick();
    for (int p = 0; p < 15; p++) begin
      tick();
      done_calc_min = 1'b1;
      tick();
      done_calc_min = 1'b0;
    end
    check("sat.iss15.id0", 32'(cand_id_0), 30);
    check("sat.iss15.v1", 32'(cand_valid_1), 1);
    tick();
    done_calc_min = 1'b1;
    set_min(16'd77, 8'd31, 16'd88, 8'd30);
    tick();
    done_calc_min = 1'b0;
    check("sat.out.res_valid", 32'(res_valid), 1);
    check_res("sat.out", 16'd77, 8'd31, 16'd88, 8'd30);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset during WAIT of a six-candidate object; a late done must not restart anything.
    start_obj = 1'b1;
    num_cand  = 6'd6;
    tick();
    start_obj = 1'b0;
    tick();
    tick();
    check("rstw.wait.busy", 32'(busy), 1);
    reset_N = 1'b0;
    tick();
    check("rstw.busy", 32'(busy), 0);
    check("rstw.start_min", 32'(start_calc_min), 0);
    check("rstw.id1", 32'(cand_id_1), 0);
    check("rstw.v1", 32'(cand_valid_1), 0);
    check("rstw.res_valid", 32'(res_valid), 0);
    check_res("rstw", 16'h0, 8'h0, 16'h0, 8'h0);
    reset_N       = 1'b1;
    done_calc_min = 1'b1;
    tick();
    done_calc_min = 1'b0;
    tick();
    check("rstw.late_done.busy", 32'(busy), 0);
    check("rstw.late_done.res_valid", 32'(res_valid), 0);

`ifdef OFLOW_CALC_MIN_TIMEOUT_EN
    // Done withheld: abort after 16 WAIT cycles.
    start_obj = 1'b1;
    num_cand  = 6'd2;
    tick();
    start_obj = 1'b0;
    tick();
    tick();
    for (int w = 1; w < 16; w++) begin
      tick();
    end
    check("to.wait16.res_valid", 32'(res_valid), 0);
    check("to.wait16.err", 32'(err_timeout), 0);
    tick();
    check("to.out.err", 32'(err_timeout), 1);
    check("to.out.res_valid", 32'(res_valid), 1);
    check_res("to.out", 16'hFFFF, 8'd0, 16'hFFFF, 8'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("to.idle.err", 32'(err_timeout), 1);
    start_obj = 1'b1;
    num_cand  = 6'd0;
    tick();
    start_obj = 1'b0;
    check("to.restart.err", 32'(err_timeout), 0);
`else
    check("noto.err", 32'(err_timeout), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oflow_calc_min_ctrl.md
OFLOW_CALC_MIN_CTRL -- requirements
Module: oflow_calc_min_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_CAND, default 32, the maximum previous-frame candidates per object.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16, the maximum WAIT cycles before abort (timeout build only).
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port reset_N, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have port start_obj, input, 1, a one-cycle request to start one current-frame object.
REQ-006 The block SHALL have port num_cand, input, $clog2(MAX_CAND+1), the candidate count, sampled with start_obj.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have ports start_score_calc and start_calc_min, output, 1 each, driving the min-calculator.
REQ-009 The block SHALL have port done_calc_min, input, 1, the min-calculator completion pulse.
REQ-010 The block SHALL have ports cand_id_0 and cand_id_1, output, ID_LEN each, the candidate ids for the two similarity lanes.
REQ-011 The block SHALL have port cand_valid_1, output, 1; when low, lane 1 forces its score to all-ones.
REQ-012 The block SHALL have ports min_score_0 and min_score_1, input, SCORE_LEN each, and min_id_0 and min_id_1, input, ID_LEN each, from the min-calculator.
REQ-013 The block SHALL have ports res_score_0, res_id_0, res_score_1 and res_id_1, output, captured results at the same widths as their inputs.
REQ-014 The block SHALL have ports res_valid, output, 1, and res_ready, input, 1, forming the result handshake to the score board.
REQ-015 The block SHALL have port err_timeout, output, 1, a sticky abort flag (timeout build only).

Function
REQ-016 The FSM SHALL have states IDLE, INIT, ISSUE, WAIT and OUT.
REQ-017 IDLE: start_obj SHALL latch num_cand, clear base to 0, and move to INIT; start_obj outside IDLE SHALL be ignored.
REQ-018 INIT: the block SHALL assert start_score_calc for exactly one cycle, then go to ISSUE, or to OUT when num_cand==0.
REQ-019 ISSUE: the block SHALL drive cand_id_0=base, cand_id_1=base+1 and cand_valid_1=(base+1<num_cand), assert start_calc_min for one cycle, and go to WAIT.
REQ-020 The candidate ids and cand_valid_1 SHALL be held stable from ISSUE until done_calc_min.
REQ-021 WAIT: on done_calc_min the block SHALL set base+=2, then go to OUT if base>=num_cand, else to ISSUE.
REQ-022 A done_calc_min outside WAIT SHALL be ignored.
REQ-023 On the cycle after the final done, the block SHALL capture min_score_*/min_id_* into the res_* registers and enter OUT.
REQ-024 OUT: res_valid SHALL be high with res_* stable until res_valid&&res_ready, then the block SHALL return to IDLE.
REQ-025 Per-object latency for N>0 candidates SHALL be 2+2*ceil(N/2)+(sum of done waits) cycles to res_valid.
REQ-026 With num_cand==0, res_score_* SHALL be all-ones and res_id_* SHALL be 0.
REQ-027 base SHALL be $clog2(MAX_CAND)+1 bits wide so that base+2 cannot wrap; num_cand>MAX_CAND SHALL be saturated to MAX_CAND.

Reset
REQ-028 While reset_N is low at a clk edge, the state SHALL be IDLE and base, the res_* registers, res_valid, busy, start_* and err_timeout SHALL be 0, including when reset occurs mid-object.
REQ-029 After reset_N is deasserted, operation SHALL resume only on a new start_obj.

Configuration
REQ-030 With OFLOW_CALC_MIN_TIMEOUT_EN defined, WAIT SHALL count cycles, and when TIMEOUT_CYC cycles pass without a done it SHALL set err_timeout, load all-ones scores and 0 ids, and go to OUT.
REQ-031 err_timeout SHALL clear only on reset or on the next start_obj.
REQ-032 With OFLOW_CALC_MIN_TIMEOUT_EN undefined, the counter SHALL be absent, err_timeout SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-033 The state enum, MAX_SCORE and the SCORE_LEN/ID_LEN-derived widths SHALL live in the shared oflow core package.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 num_cand=4, done 3 cycles after each start_calc_min, mins (5,id2),(9,id0) -> ids (0,1) then (2,3), two start_calc_min pulses, res=(5,2,9,0), res_valid held until res_ready.
REQ-036 num_cand=3 -> second ISSUE drives ids (2,3) with cand_valid_1=0.
REQ-037 num_cand=0 -> start_score_calc pulse, no start_calc_min, res scores all-ones and ids 0.
REQ-038 reset_N low during WAIT of a 6-candidate object -> IDLE and all outputs 0 on the next edge; a late done is ignored.
REQ-039 Timeout build, done withheld -> err_timeout=1 after 16 WAIT cycles and res_valid with all-ones scores.
REQ-040 start_obj while busy, and res_ready held low for 5 cycles -> start_obj ignored and res_* unchanged until the handshake.
